// File: rtl/bf16_pkg.sv
// rtl/bf16_pkg.sv - BF16/FP32 types, operand classes and constants for the BF16 multiplier
package bf16_pkg;

  typedef struct packed {
    logic       sign;
    logic [7:0] exp;
    logic [6:0] man;
  } bf16_t;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] man;
  } fp32_t;

  typedef enum logic [1:0] {
    ZERO,
    NORM,
    INF,
    NAN
  } cls_e;

  localparam int          BIAS       = 127;
  localparam logic [31:0] QNAN32     = 32'h7FC0_0000;
  localparam logic [15:0] QNAN16     = 16'h7FC0;
  localparam int          PIPE_DEPTH = 3;

  // Subnormals (exp==0, man!=0) are deliberately folded into ZERO: inputs are flushed.
  function automatic cls_e classify(input bf16_t x);
    cls_e c;
    c = NORM;
    if (x.exp == 8'd0) begin
      c = ZERO;
    end else if (x.exp == 8'hFF) begin
      c = (x.man == 7'd0) ? INF : NAN;
    end
    return c;
  endfunction

endpackage

// File: rtl/bf16_mul_lane.sv
// rtl/bf16_mul_lane.sv - one BF16 x BF16 multiplier lane, 3 register stages sharing one enable
// Ports: clk_i/rst_ni clock and async active-low reset; en_i advances all three stages;
//        a_i/b_i BF16 operands; res_o FP32 or zero-extended BF16 product; flags_o {nan, overflow, underflow}.
module bf16_mul_lane
  import bf16_pkg::*;
#(
  parameter bit OUT_BF16 = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic [31:0] res_o,
  output logic [2:0]  flags_o
);

  // Stage 1: unpack and classify
  bf16_t      a, b;
  logic       s1_sign_d, s1_sign_q;
  cls_e       s1_cls_a_d, s1_cls_a_q, s1_cls_b_d, s1_cls_b_q;
  logic [7:0] s1_ea_q, s1_eb_q;
  logic [7:0] s1_ma_d, s1_ma_q, s1_mb_d, s1_mb_q;

  assign a          = a_i;
  assign b          = b_i;
  assign s1_sign_d  = a.sign ^ b.sign;
  assign s1_cls_a_d = classify(a);
  assign s1_cls_b_d = classify(b);
  assign s1_ma_d    = {1'b1, a.man};
  assign s1_mb_d    = {1'b1, b.man};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_sign_q  <= 1'b0;
      s1_cls_a_q <= ZERO;
      s1_cls_b_q <= ZERO;
      s1_ea_q    <= 8'd0;
      s1_eb_q    <= 8'd0;
      s1_ma_q    <= 8'd0;
      s1_mb_q    <= 8'd0;
    end else if (en_i) begin
      s1_sign_q  <= s1_sign_d;
      s1_cls_a_q <= s1_cls_a_d;
      s1_cls_b_q <= s1_cls_b_d;
      s1_ea_q    <= a.exp;
      s1_eb_q    <= b.exp;
      s1_ma_q    <= s1_ma_d;
      s1_mb_q    <= s1_mb_d;
    end
  end

  // Stage 2: mantissa product, biased exponent sum, special-case decode
  logic              s2_sign_q;
  logic              s2_nan_d, s2_nan_q, s2_inf_d, s2_inf_q, s2_zero_d, s2_zero_q;
  logic [15:0]       s2_prod_d, s2_prod_q;
  logic signed [9:0] s2_exp_d, s2_exp_q;

  assign s2_nan_d  = (s1_cls_a_q == NAN) || (s1_cls_b_q == NAN) ||
                     ((s1_cls_a_q == INF) && (s1_cls_b_q == ZERO)) ||
                     ((s1_cls_a_q == ZERO) && (s1_cls_b_q == INF));
  assign s2_inf_d  = (s1_cls_a_q == INF) || (s1_cls_b_q == INF);
  assign s2_zero_d = (s1_cls_a_q == ZERO) || (s1_cls_b_q == ZERO);
  assign s2_prod_d = {8'd0, s1_ma_q} * {8'd0, s1_mb_q};
  // Ten bits hold the full range 2-127 .. 508-127 plus normalise/round carries.
  assign s2_exp_d  = {2'b00, s1_ea_q} + {2'b00, s1_eb_q} - 10'(BIAS);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s2_sign_q <= 1'b0;
      s2_nan_q  <= 1'b0;
      s2_inf_q  <= 1'b0;
      s2_zero_q <= 1'b0;
      s2_prod_q <= 16'd0;
      s2_exp_q  <= 10'sd0;
    end else if (en_i) begin
      s2_sign_q <= s1_sign_q;
      s2_nan_q  <= s2_nan_d;
      s2_inf_q  <= s2_inf_d;
      s2_zero_q <= s2_zero_d;
      s2_prod_q <= s2_prod_d;
      s2_exp_q  <= s2_exp_d;
    end
  end

  // Stage 3: normalise, round (BF16 only), range check, specials, pack
  logic [14:0]       frac15;
  logic signed [9:0] exp_n, exp_r;
  logic              guard, sticky, rnd_up, carry;
  logic [6:0]        man_r;
  logic [7:0]        exp_o;
  logic [22:0]       man_o;
  fp32_t             r32;
  bf16_t             r16;
  logic [31:0]       res_d, res_q;
  logic [2:0]        flags_d, flags_q;

  always_comb begin
    // Product of two 1.x mantissas lies in [1,4); bit 15 set means the value is >= 2.
    frac15 = s2_prod_q[15] ? s2_prod_q[14:0] : {s2_prod_q[13:0], 1'b0};
    exp_n  = s2_exp_q + $signed({9'd0, s2_prod_q[15]});
    guard  = frac15[7];
    sticky = |frac15[6:0];
    rnd_up = OUT_BF16 && guard && (sticky || frac15[8]);
    {carry, man_r} = {1'b0, frac15[14:8]} + {7'd0, rnd_up};
    exp_r  = exp_n + $signed({9'd0, carry});

    exp_o   = 8'h00;
    man_o   = 23'd0;
    flags_d = 3'b000;
    if (s2_nan_q) begin
      flags_d = 3'b100;
    end else if (s2_inf_q) begin
      exp_o = 8'hFF;
    end else if (s2_zero_q) begin
      exp_o = 8'h00;
    end else if (exp_r >= 10'sd255) begin
      exp_o   = 8'hFF;
      flags_d = 3'b010;
    end else if (exp_r <= 10'sd0) begin
      flags_d = 3'b001;
    end else begin
      exp_o = exp_r[7:0];
      man_o = OUT_BF16 ? {man_r, 16'd0} : {frac15, 8'd0};
    end

    r32   = {s2_sign_q, exp_o, man_o};
    r16   = {s2_sign_q, exp_o, man_o[22:16]};
    res_d = s2_nan_q ? (OUT_BF16 ? {16'd0, QNAN16} : QNAN32)
                     : (OUT_BF16 ? {16'd0, r16} : r32);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      res_q   <= 32'd0;
      flags_q <= 3'b000;
    end else if (en_i) begin
      res_q   <= res_d;
      flags_q <= flags_d;
    end
  end

  assign res_o   = res_q;
  assign flags_o = flags_q;

endmodule

// File: rtl/bf16_mul_pipe.sv
// rtl/bf16_mul_pipe.sv - multi-lane 3-stage BF16 multiplier with valid/ready handshake
// Ports: clk/rst_n clock and async active-low reset; in_valid/in_ready/in_a/in_b operand stream
//        (lane i at [16*i+15:16*i]); out_valid/out_ready/out_data/out_flags result stream
//        (lane i at [32*i+31:32*i], flags {nan, overflow, underflow} at [3*i+2:3*i]).
module bf16_mul_pipe
  import bf16_pkg::*;
#(
  parameter int unsigned LANES    = 4,
  parameter bit          OUT_BF16 = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [LANES*16-1:0]  in_a,
  input  logic [LANES*16-1:0]  in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LANES*32-1:0]  out_data,
  output logic [LANES*3-1:0]   out_flags
);

  logic                  adv;
  logic [PIPE_DEPTH-1:0] vld_d, vld_q;

  // The whole pipe moves as one; bubbles are kept, so a stall at the output freezes every stage.
  assign adv       = out_ready | ~out_valid;
  assign in_ready  = adv;
  assign out_valid = vld_q[PIPE_DEPTH-1];
  assign vld_d     = {vld_q[PIPE_DEPTH-2:0], in_valid};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
    end else if (adv) begin
      vld_q <= vld_d;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    bf16_mul_lane #(
      .OUT_BF16(OUT_BF16)
    ) u_lane (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .en_i   (adv),
      .a_i    (in_a[16*i +: 16]),
      .b_i    (in_b[16*i +: 16]),
      .res_o  (out_data[32*i +: 32]),
      .flags_o(out_flags[3*i +: 3])
    );
  end

endmodule

// File: tb/tb_bf16_mul_pipe.sv
// tb/tb_bf16_mul_pipe.sv - self-checking bench for bf16_mul_pipe in FP32 and BF16 output modes
module tb_bf16_mul_pipe;

  localparam int LANES = 4;
  localparam int NVEC  = 24;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                in_valid, out_ready;
  logic [LANES*16-1:0] in_a, in_b;
  logic                in_ready_f, in_ready_h, out_valid_f, out_valid_h;
  logic [LANES*32-1:0] data_f, data_h;
  logic [LANES*3-1:0]  flags_f, flags_h;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  bf16_mul_pipe #(.LANES(LANES), .OUT_BF16(1'b0)) dut_f (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_f),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid_f), .out_ready(out_ready),
    .out_data(data_f), .out_flags(flags_f)
  );

  bf16_mul_pipe #(.LANES(LANES), .OUT_BF16(1'b1)) dut_h (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_h),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid_h), .out_ready(out_ready),
    .out_data(data_h), .out_flags(flags_h)
  );

  // Reference: real-valued product of the decoded operands, re-encoded from its IEEE double image.
  function automatic void ref_mul(input logic [15:0] a, input logic [15:0] b, input bit half,
                                  output logic [31:0] r, output logic [2:0] f);
    logic        za, ia, na, zb, ib, nb, s;
    logic [63:0] ab, bb, pb;
    real         p;
    int          e;
    logic [51:0] dm;
    logic [7:0]  m8;
    logic [44:0] rest;
    za = (a[14:7] == 8'h00);
    ia = (a[14:7] == 8'hFF) && (a[6:0] == 7'd0);
    na = (a[14:7] == 8'hFF) && (a[6:0] != 7'd0);
    zb = (b[14:7] == 8'h00);
    ib = (b[14:7] == 8'hFF) && (b[6:0] == 7'd0);
    nb = (b[14:7] == 8'hFF) && (b[6:0] != 7'd0);
    s  = a[15] ^ b[15];
    f  = 3'b000;
    if (na || nb || (ia && zb) || (za && ib)) begin
      r = half ? 32'h0000_7FC0 : 32'h7FC0_0000;
      f = 3'b100;
      return;
    end
    if (ia || ib) begin
      r = half ? {16'd0, s, 8'hFF, 7'd0} : {s, 8'hFF, 23'd0};
      return;
    end
    if (za || zb) begin
      r = half ? {16'd0, s, 15'd0} : {s, 31'd0};
      return;
    end
    ab = {1'b0, 11'(int'(a[14:7]) + 896), a[6:0], 45'd0};
    bb = {1'b0, 11'(int'(b[14:7]) + 896), b[6:0], 45'd0};
    p  = $bitstoreal(ab) * $bitstoreal(bb);
    pb = $realtobits(p);
    e  = int'(pb[62:52]) - 1023 + 127;
    dm = pb[51:0];
    m8 = {1'b0, dm[51:45]};
    if (half) begin
      rest = dm[44:0];
      if (rest > 45'h1000_0000_0000 || (rest == 45'h1000_0000_0000 && m8[0])) m8 = m8 + 8'd1;
      if (m8[7]) begin
        m8 = 8'd0;
        e  = e + 1;
      end
    end
    if (e >= 255) begin
      r = half ? {16'd0, s, 8'hFF, 7'd0} : {s, 8'hFF, 23'd0};
      f = 3'b010;
    end else if (e <= 0) begin
      r = half ? {16'd0, s, 15'd0} : {s, 31'd0};
      f = 3'b001;
    end else begin
      r = half ? {16'd0, s, 8'(e), m8[6:0]} : {s, 8'(e), dm[51:29]};
    end
  endfunction

  function automatic void ref_vec(input logic [LANES*16-1:0] a, input logic [LANES*16-1:0] b,
                                  input bit half, output logic [LANES*32-1:0] r,
                                  output logic [LANES*3-1:0] f);
    logic [31:0] rl;
    logic [2:0]  fl;
    for (int l = 0; l < LANES; l++) begin
      ref_mul(a[16*l +: 16], b[16*l +: 16], half, rl, fl);
      r[32*l +: 32] = rl;
      f[3*l +: 3]   = fl;
    end
  endfunction

  function automatic logic [15:0] rand_bf16();
    logic [7:0] e;
    int         k;
    k = $urandom_range(0, 11);
    case (k)
      0:       e = 8'h00;
      1, 2:    e = 8'hFF;
      3:       e = 8'($urandom_range(200, 254));
      4:       e = 8'($urandom_range(1, 60));
      default: e = 8'($urandom_range(100, 154));
    endcase
    if (k == 1) return {1'($urandom), e, 7'd0};
    return {1'($urandom), e, 7'($urandom)};
  endfunction

  function automatic logic [LANES*16-1:0] rand_vec();
    logic [LANES*16-1:0] v;
    for (int l = 0; l < LANES; l++) v[16*l +: 16] = rand_bf16();
    return v;
  endfunction

  task automatic test_reset;
    #1;
    chk_cnt++;
    if (out_valid_f !== 1'b0 || out_valid_h !== 1'b0) $display("FAIL reset_out_valid: got %b/%b expected 0", out_valid_f, out_valid_h);
    else pass_cnt++;
    chk_cnt++;
    if (data_f !== '0 || data_h !== '0) $display("FAIL reset_out_data: got %h/%h expected 0", data_f, data_h);
    else pass_cnt++;
    chk_cnt++;
    if (flags_f !== '0 || flags_h !== '0) $display("FAIL reset_out_flags: got %h/%h expected 0", flags_f, flags_h);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk_cnt++;
    if (in_ready_f !== 1'b1 || in_ready_h !== 1'b1 || out_valid_f !== 1'b0)
      $display("FAIL reset_in_ready: got in_ready %b/%b out_valid %b expected 1/1/0", in_ready_f, in_ready_h, out_valid_f);
    else pass_cnt++;
  endtask

  task automatic test_directed;
    logic [15:0]         op_a[10], op_b[10];
    logic [31:0]         ex_f[10], ex_h[10];
    logic [2:0]          fl_f[10], fl_h[10];
    logic [LANES*32-1:0] rf, rh;
    logic [LANES*3-1:0]  ff, fh;
    int                  lat;
    op_a = '{16'h3FC0, 16'h4000, 16'h3F81, 16'h3FC1, 16'h7F80, 16'h7F00, 16'h0080, 16'h0001, 16'hBFC0, 16'hFF80};
    op_b = '{16'h3FC0, 16'h4000, 16'h3FC0, 16'h3FC1, 16'h0000, 16'h4000, 16'h0080, 16'h3F80, 16'h3FC0, 16'h4000};
    ex_f = '{32'h4010_0000, 32'h4080_0000, 32'h3FC1_8000, 32'h4011_8100, 32'h7FC0_0000,
             32'h7F80_0000, 32'h0000_0000, 32'h0000_0000, 32'hC010_0000, 32'hFF80_0000};
    ex_h = '{32'h4010, 32'h4080, 32'h3FC2, 32'h4012, 32'h7FC0, 32'h7F80, 32'h0000, 32'h0000, 32'hC010, 32'hFF80};
    fl_f = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b100, 3'b010, 3'b001, 3'b000, 3'b000, 3'b000};
    fl_h = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b100, 3'b010, 3'b001, 3'b000, 3'b000, 3'b000};
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_a = rand_vec();
      in_b = rand_vec();
      in_a[15:0] = op_a[i];
      in_b[15:0] = op_b[i];
      in_valid = 1'b1;
      ref_vec(in_a, in_b, 1'b0, rf, ff);
      ref_vec(in_a, in_b, 1'b1, rh, fh);
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid_f && lat < 10) begin
        @(negedge clk);
        lat++;
      end
      chk_cnt++;
      if (lat !== 3 || out_valid_h !== 1'b1) $display("FAIL latency_%0d: got %0d cycles (bf16 valid %b) expected 3", i, lat, out_valid_h);
      else pass_cnt++;
      chk_cnt++;
      if (data_f[31:0] !== ex_f[i] || flags_f[2:0] !== fl_f[i])
        $display("FAIL fp32_%h_x_%h: got %h flags %b expected %h flags %b", op_a[i], op_b[i], data_f[31:0], flags_f[2:0], ex_f[i], fl_f[i]);
      else pass_cnt++;
      chk_cnt++;
      if (data_h[31:0] !== ex_h[i] || flags_h[2:0] !== fl_h[i])
        $display("FAIL bf16_%h_x_%h: got %h flags %b expected %h flags %b", op_a[i], op_b[i], data_h[31:0], flags_h[2:0], ex_h[i], fl_h[i]);
      else pass_cnt++;
      chk_cnt++;
      if (data_f[LANES*32-1:32] !== rf[LANES*32-1:32] || flags_f[LANES*3-1:3] !== ff[LANES*3-1:3] ||
          data_h[LANES*32-1:32] !== rh[LANES*32-1:32] || flags_h[LANES*3-1:3] !== fh[LANES*3-1:3])
        $display("FAIL other_lanes_%0d: got %h/%h expected %h/%h", i, data_f, data_h, rf, rh);
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back;
    logic [LANES*32-1:0] qf[$], qh[$];
    logic [LANES*3-1:0]  qff[$], qfh[$];
    logic [LANES*32-1:0] rf, rh;
    logic [LANES*3-1:0]  ff, fh;
    int                  sent, rcvd, cyc, extra;
    bit                  acc, stall_prev;
    sent = 0; rcvd = 0; cyc = 0; extra = 0; acc = 0; stall_prev = 0;
    in_valid = 1'b0;
    while (rcvd < NVEC && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (acc) in_valid = 1'b0;
      acc = 0;
      out_ready = ($urandom_range(0, 2) != 0);
      if (!in_valid && sent < NVEC && $urandom_range(0, 3) != 0) begin
        in_a = rand_vec();
        in_b = rand_vec();
        in_valid = 1'b1;
      end
      #1;
      if (stall_prev) begin
        chk_cnt++;
        if (out_valid_f !== 1'b1) $display("FAIL stall_hold_valid: got %b expected 1", out_valid_f);
        else pass_cnt++;
      end
      if (out_valid_f) begin
        chk_cnt++;
        if (qf.size() == 0) begin
          $display("FAIL unexpected_output: got %h with no result outstanding", data_f);
        end else if (data_f !== qf[0] || flags_f !== qff[0] || data_h !== qh[0] || flags_h !== qfh[0] || out_valid_h !== 1'b1) begin
          $display("FAIL stream_result_%0d: got %h %h / %h %h expected %h %h / %h %h",
                   rcvd, data_f, flags_f, data_h, flags_h, qf[0], qff[0], qh[0], qfh[0]);
        end else pass_cnt++;
        if (out_ready && qf.size() != 0) begin
          void'(qf.pop_front());
          void'(qff.pop_front());
          void'(qh.pop_front());
          void'(qfh.pop_front());
          rcvd++;
        end
      end
      stall_prev = out_valid_f && !out_ready;
      if (in_valid && in_ready_f) begin
        ref_vec(in_a, in_b, 1'b0, rf, ff);
        ref_vec(in_a, in_b, 1'b1, rh, fh);
        qf.push_back(rf);
        qff.push_back(ff);
        qh.push_back(rh);
        qfh.push_back(fh);
        sent++;
        acc = 1;
      end
    end
    chk_cnt++;
    if (rcvd !== NVEC) $display("FAIL stream_count: got %0d results expected %0d", rcvd, NVEC);
    else pass_cnt++;
    @(negedge clk);
    if (acc) in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (out_valid_f || out_valid_h) extra++;
    end
    chk_cnt++;
    if (extra !== 0) $display("FAIL stream_no_duplicate: got %0d extra valid cycles expected 0", extra);
    else pass_cnt++;
  endtask

  task automatic test_reset_in_flight;
    logic [LANES*32-1:0] rf, rh;
    logic [LANES*3-1:0]  ff, fh;
    int                  stale, lat;
    stale = 0;
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      in_a = rand_vec();
      in_b = rand_vec();
      in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk_cnt++;
    if (out_valid_f !== 1'b1) $display("FAIL flight_full: got out_valid %b expected 1", out_valid_f);
    else pass_cnt++;
    rst_n = 1'b0;
    #1;
    chk_cnt++;
    if (out_valid_f !== 1'b0 || out_valid_h !== 1'b0 || data_f !== '0 || flags_f !== '0)
      $display("FAIL async_reset: got valid %b/%b data %h expected 0", out_valid_f, out_valid_h, data_f);
    else pass_cnt++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (out_valid_f || out_valid_h) stale++;
    end
    chk_cnt++;
    if (stale !== 0) $display("FAIL stale_after_reset: got %0d valid cycles expected 0", stale);
    else pass_cnt++;
    in_a = rand_vec();
    in_b = rand_vec();
    in_valid = 1'b1;
    ref_vec(in_a, in_b, 1'b0, rf, ff);
    ref_vec(in_a, in_b, 1'b1, rh, fh);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid_f && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk_cnt++;
    if (lat !== 3) $display("FAIL post_reset_latency: got %0d expected 3", lat);
    else pass_cnt++;
    chk_cnt++;
    if (data_f !== rf || flags_f !== ff || data_h !== rh || flags_h !== fh)
      $display("FAIL post_reset_result: got %h/%h expected %h/%h", data_f, data_h, rf, rh);
    else pass_cnt++;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_a      = '0;
    in_b      = '0;
    repeat (3) @(negedge clk);
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_in_flight();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
